// File: rtl/multi_sig_ctrl.sv
// N-approach round-robin traffic-signal controller; approach 0 rests GREEN when idle.
// All outputs registered; requests latched in pend_q, hold freezes phase timing only.
module multi_sig_ctrl #(
  parameter int N_APPR    = 2,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int Y2R       = 3,
  parameter int R2G       = 2,
  parameter int CW        = 4,
  parameter int IW        = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [N_APPR-1:0]     req,
  input  logic                  hold,
  output logic [2*N_APPR-1:0]   sig,
  output logic [IW-1:0]         active,
  output logic                  switch
);

  typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_t;

  localparam logic [1:0]    SIG_RED = 2'd0;
  localparam logic [1:0]    SIG_YEL = 2'd1;
  localparam logic [1:0]    SIG_GRN = 2'd2;
  localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] Y2R_M1  = CW'(Y2R - 1);
  localparam logic [CW-1:0] R2G_M1  = CW'(R2G - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         active_q, active_d;
  logic [IW-1:0]         next_q, next_d;
  logic [N_APPR-1:0]     pend_q, pend_d;
  logic [2*N_APPR-1:0]   sig_q, sig_d;
  logic                  switch_q, switch_d;

  logic                  other;
  logic                  req_act;
  logic                  hi_found, lo_found;
  logic [IW-1:0]         hi_idx, lo_idx, nxt;
  logic                  gap_out, max_out, go_home;
  logic [1:0]            head;

  // Round-robin pick: lowest pending index above active, else lowest below it.
  always_comb begin
    other    = 1'b0;
    req_act  = 1'b0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_APPR - 1; i >= 0; i--) begin
      if (IW'(i) == active_q) begin
        req_act = req[i];
      end else if (pend_q[i]) begin
        other = 1'b1;
        if (IW'(i) > active_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IW'(i);
        end
      end
    end
    nxt = hi_found ? hi_idx : (lo_found ? lo_idx : '0);
  end

  always_comb begin
    gap_out = (timer_q >= GMIN_M1) && other && !req_act;
    max_out = (timer_q >= GMAX_M1) && other;
    go_home = (timer_q >= GMIN_M1) && !other && (active_q != '0) && !req_act;
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
    next_d   = next_q;
    pend_d   = pend_q | req;
    switch_d = 1'b0;
    case (state_q)
      ST_GREEN: begin
        if (!hold) begin
          if (gap_out || max_out || go_home) begin
            state_d = ST_YELLOW;
            timer_d = '0;
            next_d  = nxt;
          end else if (timer_q < GMAX_M1) begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_YELLOW: begin
        if (!hold) begin
          if (timer_q >= Y2R_M1) begin
            state_d = ST_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_ALLRED: begin
        if (!hold) begin
          if (timer_q >= R2G_M1) begin
            state_d  = ST_GREEN;
            timer_d  = '0;
            active_d = next_q;
            switch_d = 1'b1;
            for (int i = 0; i < N_APPR; i++) begin
              if (IW'(i) == next_q) pend_d[i] = 1'b0;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_GREEN;
        timer_d = '0;
      end
    endcase
  end

  // Heads are computed from the next state so they change on the same edge as it.
  always_comb begin
    head = SIG_RED;
    case (state_d)
      ST_GREEN:  head = SIG_GRN;
      ST_YELLOW: head = SIG_YEL;
      default:   head = SIG_RED;
    endcase
    sig_d = '0;
    for (int i = 0; i < N_APPR; i++) begin
      sig_d[2*i +: 2] = (IW'(i) == active_d) ? head : SIG_RED;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_GREEN;
      timer_q  <= '0;
      active_q <= '0;
      next_q   <= '0;
      pend_q   <= '0;
      sig_q    <= {{(2*N_APPR-2){1'b0}}, SIG_GRN};
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      next_q   <= next_d;
      pend_q   <= pend_d;
      sig_q    <= sig_d;
      switch_q <= switch_d;
    end
  end

  assign sig    = sig_q;
  assign active = active_q;
  assign switch = switch_q;

endmodule

// File: tb/tb_multi_sig_ctrl.sv
// Directed bench for multi_sig_ctrl: 2-approach instance for timing/hold/clear,
// 3-approach instance for round-robin order.
module tb_multi_sig_ctrl;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [1:0] req   = 2'b00;
  logic       hold  = 1'b0;
  logic [3:0] sig;
  logic [0:0] active;
  logic       switch;

  logic       clear3 = 1'b1;
  logic [2:0] req3   = 3'b000;
  logic       hold3  = 1'b0;
  logic [5:0] sig3;
  logic [1:0] active3;
  logic       switch3;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int bad;

  always #5 clock = ~clock;

  multi_sig_ctrl u_dut (
    .clock(clock), .clear(clear), .req(req), .hold(hold),
    .sig(sig), .active(active), .switch(switch)
  );

  multi_sig_ctrl #(.N_APPR(3), .IW(2)) u_dut3 (
    .clock(clock), .clear(clear3), .req(req3), .hold(hold3),
    .sig(sig3), .active(active3), .switch(switch3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] cur(input bit use3);
    return use3 ? sig3 : {2'b00, sig};
  endfunction

  // Counts samples for which the selected heads keep value v (bounded).
  task automatic meas(input string tag, input bit use3, input logic [5:0] v, input int exp_len);
    int n;
    n = 0;
    while (cur(use3) === v && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n, exp_len);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    req   = 2'b00;
    hold  = 1'b0;
    tick();
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // 1: reset values, then idle home GREEN for 100 cycles
    do_reset();
    chk("t1_rst_sig", int'(sig), 4'b0010);
    chk("t1_rst_active", int'(active), 0);
    chk("t1_rst_switch", int'(switch), 0);
    chk("t1_rst_pend", int'(u_dut.pend_q), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sig !== 4'b0010 || switch !== 1'b0) bad++;
    end
    chk("t1_idle_home", bad, 0);

    // 2: req[1] held from reset release
    do_reset();
    req = 2'b10;
    meas("t2_g0_len", 1'b0, 6'b000010, 4);
    meas("t2_y0_len", 1'b0, 6'b000001, 3);
    meas("t2_r_len",  1'b0, 6'b000000, 2);
    chk("t2_sig1", int'(sig), 4'b1000);
    chk("t2_active1", int'(active), 1);
    chk("t2_switch_on", int'(switch), 1);
    tick();
    chk("t2_switch_off", int'(switch), 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sig !== 4'b1000 || switch !== 1'b0) bad++;
    end
    chk("t2_hold_green1", bad, 0);

    // 3: both requesting -> max-out alternation
    do_reset();
    req = 2'b11;
    meas("t3_g0_len", 1'b0, 6'b000010, 8);
    meas("t3_y0_len", 1'b0, 6'b000001, 3);
    meas("t3_r0_len", 1'b0, 6'b000000, 2);
    chk("t3_active1", int'(active), 1);
    meas("t3_g1_len", 1'b0, 6'b001000, 8);
    meas("t3_y1_len", 1'b0, 6'b000100, 3);
    meas("t3_r1_len", 1'b0, 6'b000000, 2);
    chk("t3_active0", int'(active), 0);
    chk("t3_switch", int'(switch), 1);
    meas("t3_g0b_len", 1'b0, 6'b000010, 8);

    // 4: single-cycle req[1] pulse at timer=1 is latched and served
    do_reset();
    tick();
    req = 2'b10;
    tick();
    req = 2'b00;
    meas("t4_g0_rest", 1'b0, 6'b000010, 2);
    meas("t4_y0_len",  1'b0, 6'b000001, 3);
    meas("t4_r0_len",  1'b0, 6'b000000, 2);
    chk("t4_active1", int'(active), 1);
    meas("t4_g1_len",  1'b0, 6'b001000, 4);
    meas("t4_y1_len",  1'b0, 6'b000100, 3);
    meas("t4_r1_len",  1'b0, 6'b000000, 2);
    chk("t4_home_sig", int'(sig), 4'b0010);
    chk("t4_home_active", int'(active), 0);
    chk("t4_home_switch", int'(switch), 1);
    chk("t4_pend_clear", int'(u_dut.pend_q), 0);

    // 5: three approaches, req[2] then req[1] -> order 1, 2, 0
    clear3 = 1'b0;
    req3 = 3'b100;
    tick();
    req3 = 3'b010;
    tick();
    req3 = 3'b000;
    meas("t5_g0_rest", 1'b1, 6'b000010, 2);
    meas("t5_y0_len",  1'b1, 6'b000001, 3);
    meas("t5_r0_len",  1'b1, 6'b000000, 2);
    chk("t5_first_1", int'(active3), 1);
    chk("t5_switch_1", int'(switch3), 1);
    meas("t5_g1_len",  1'b1, 6'b001000, 4);
    meas("t5_y1_len",  1'b1, 6'b000100, 3);
    meas("t5_r1_len",  1'b1, 6'b000000, 2);
    chk("t5_second_2", int'(active3), 2);
    meas("t5_g2_len",  1'b1, 6'b100000, 4);
    meas("t5_y2_len",  1'b1, 6'b010000, 3);
    meas("t5_r2_len",  1'b1, 6'b000000, 2);
    chk("t5_third_0", int'(active3), 0);
    chk("t5_home_sig", int'(sig3), 6'b000010);

    // 6: async clear mid-YELLOW on approach 1, then hold stretch
    do_reset();
    req = 2'b10;
    tick();
    req = 2'b00;
    meas("t6_g0_rest", 1'b0, 6'b000010, 3);
    meas("t6_y0_len",  1'b0, 6'b000001, 3);
    meas("t6_r0_len",  1'b0, 6'b000000, 2);
    meas("t6_g1_len",  1'b0, 6'b001000, 4);
    tick();
    chk("t6_in_yellow1", int'(sig), 4'b0100);
    #2;
    clear = 1'b1;
    #1;
    chk("t6_clr_sig", int'(sig), 4'b0010);
    chk("t6_clr_active", int'(active), 0);
    chk("t6_clr_pend", int'(u_dut.pend_q), 0);
    clear = 1'b0;
    req = 2'b10;
    tick();
    tick();
    hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sig !== 4'b0010 || switch !== 1'b0) bad++;
    end
    chk("t6_hold_frozen", bad, 0);
    hold = 1'b0;
    meas("t6_g0_after_hold", 1'b0, 6'b000010, 2);
    meas("t6_y0_after_hold", 1'b0, 6'b000001, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
